// File: rtl/mc_pkg.sv
// Shared types and DDR3-1600 timing defaults for the memory controller core.
package mc_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_PREA = 2'd1,
        CMD_REF  = 2'd2
    } ref_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_PREA,
        ST_WAIT_RP,
        ST_REF,
        ST_WAIT_RFC
    } ref_state_e;

    localparam int DEF_TREFI = 6240;
    localparam int DEF_TRP   = 11;
    localparam int DEF_TRFC  = 128;

endpackage

// File: rtl/refresh_interval_timer.sv
// Refresh interval counter: one-cycle tick every trefi enabled cycles.
module refresh_interval_timer #(
    parameter int C_TREFI_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [C_TREFI_WIDTH-1:0] trefi,
    output logic                     tick
);
    localparam logic [C_TREFI_WIDTH-1:0] ONE = C_TREFI_WIDTH'(1);

    logic [C_TREFI_WIDTH-1:0] count;
    logic                     loaded;
    logic                     running;

    // The first edge after reset only loads trefi-1, since the reset value cannot follow a port.
    assign running = enable && (trefi != '0) && loaded;
    assign tick    = running && (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            loaded <= 1'b0;
        end else begin
            loaded <= 1'b1;
            if (!running || count == '0) begin
                count <= trefi - ONE;
            end else begin
                count <= count - ONE;
            end
        end
    end

endmodule

// File: rtl/refresh_scheduler.sv
// DDR auto-refresh scheduler: tracks postponed refreshes, claims the DFI bus,
// and issues PRECHARGE-ALL followed by one or more REFRESH commands.
module refresh_scheduler
    import mc_pkg::*;
#(
    parameter int C_TREFI_WIDTH  = 16,
    parameter int C_TRP_WIDTH    = 6,
    parameter int C_TRFC_WIDTH   = 10,
    parameter int C_MAX_POSTPONE = 8
) (
    input  logic                                  core_clk,
    input  logic                                  core_arst,
    input  logic                                  enable,
    input  logic                                  idle_hint,
    input  logic [C_TREFI_WIDTH-1:0]              trefi,
    input  logic [C_TRP_WIDTH-1:0]                trp,
    input  logic [C_TRFC_WIDTH-1:0]               trfc,
    output logic                                  bus_req,
    input  logic                                  bus_gnt,
    output logic                                  cmd_valid,
    output logic [1:0]                            cmd,
    output logic [$clog2(C_MAX_POSTPONE+1)-1:0]   pending,
    output logic                                  urgent,
    output logic                                  overflow,
    output ref_state_e                            fsm_state
);
    localparam int PW = $clog2(C_MAX_POSTPONE + 1);
    localparam int DW = (C_TRFC_WIDTH > C_TRP_WIDTH) ? C_TRFC_WIDTH : C_TRP_WIDTH;
    localparam logic [PW-1:0] P_ONE = PW'(1);
    localparam logic [PW-1:0] P_MAX = PW'(C_MAX_POSTPONE);
    localparam logic [PW-1:0] P_URG = PW'(C_MAX_POSTPONE - 1);
    localparam logic [DW-1:0] D_ONE = DW'(1);
    localparam logic [DW-1:0] D_TWO = DW'(2);

    ref_state_e      state;
    logic            tick;
    logic            inc;
    logic            ref_issue;
    logic            burst;
    logic            rp_done;
    logic            rfc_done;
    logic [PW-1:0]   pending_nxt;
    logic [DW-1:0]   delay;
    logic [DW-1:0]   rp_ext;
    logic [DW-1:0]   rfc_ext;

    refresh_interval_timer #(
        .C_TREFI_WIDTH(C_TREFI_WIDTH)
    ) u_timer (
        .clk    (core_clk),
        .rst    (core_arst),
        .enable (enable),
        .trefi  (trefi),
        .tick   (tick)
    );

    assign rp_ext    = DW'(trp);
    assign rfc_ext   = DW'(trfc);
    assign urgent    = pending >= P_URG;
    assign ref_issue = state == ST_REF;
    assign inc       = tick && (pending != P_MAX);
    assign fsm_state = state;

    // Delays of 0 or 1 skip the wait state; otherwise the wait state runs delay-1 cycles.
    assign rp_done  = (state == ST_PREA && rp_ext <= D_ONE) || (state == ST_WAIT_RP && delay == '0);
    assign rfc_done = (state == ST_REF && rfc_ext <= D_ONE) || (state == ST_WAIT_RFC && delay == '0);

    always_comb begin
        pending_nxt = pending;
        if (inc && !ref_issue) begin
            pending_nxt = pending + P_ONE;
        end else if (!inc && ref_issue) begin
            pending_nxt = pending - P_ONE;
        end
    end

    // bus_req rises in REQ and holds until IDLE; bus_gnt, once high, is owned by us until bus_req drops.
    always_ff @(posedge core_clk or posedge core_arst) begin
        if (core_arst) begin
            state     <= ST_IDLE;
            bus_req   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            pending   <= '0;
            overflow  <= 1'b0;
            burst     <= 1'b0;
            delay     <= '0;
        end else begin
            pending   <= pending_nxt;
            cmd_valid <= 1'b0;
            cmd       <= CMD_NOP;
            if (tick && pending == P_MAX) begin
                overflow <= 1'b1;
            end
            if (rp_done) begin
                state     <= ST_REF;
                cmd_valid <= 1'b1;
                cmd       <= CMD_REF;
                burst     <= urgent;
            end else if (rfc_done) begin
                if (burst && pending_nxt != '0) begin
                    state     <= ST_REF;
                    cmd_valid <= 1'b1;
                    cmd       <= CMD_REF;
                end else begin
                    state   <= ST_IDLE;
                    bus_req <= 1'b0;
                    burst   <= 1'b0;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enable && pending != '0 && (idle_hint || urgent)) begin
                            state   <= ST_REQ;
                            bus_req <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (bus_gnt) begin
                            state     <= ST_PREA;
                            cmd_valid <= 1'b1;
                            cmd       <= CMD_PREA;
                        end
                    end
                    ST_PREA: begin
                        state <= ST_WAIT_RP;
                        delay <= rp_ext - D_TWO;
                    end
                    ST_WAIT_RP:  delay <= delay - D_ONE;
                    ST_REF: begin
                        state <= ST_WAIT_RFC;
                        delay <= rfc_ext - D_TWO;
                    end
                    ST_WAIT_RFC: delay <= delay - D_ONE;
                    default:     state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler: directed scenarios plus random traffic against a
// timestamp-based reference model of the refresh rules.
module tb_refresh_scheduler;
    import mc_pkg::*;

    localparam int MAXP = 8;

    logic        core_clk  = 1'b0;
    logic        core_arst = 1'b1;
    logic        enable    = 1'b0;
    logic        idle_hint = 1'b0;
    logic [15:0] trefi     = 16'd0;
    logic [5:0]  trp       = 6'd0;
    logic [9:0]  trfc      = 10'd0;
    logic        gnt_allow = 1'b0;
    logic        bus_req;
    logic        bus_gnt;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic [3:0]  pending;
    logic        urgent;
    logic        overflow;
    ref_state_e  fsm_state;

    assign bus_gnt = gnt_allow & bus_req;

    refresh_scheduler dut (
        .core_clk  (core_clk),
        .core_arst (core_arst),
        .enable    (enable),
        .idle_hint (idle_hint),
        .trefi     (trefi),
        .trp       (trp),
        .trfc      (trfc),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .pending   (pending),
        .urgent    (urgent),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    always #5 core_clk = ~core_clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [1:0] exp_q[$];

    // reference model state
    int cyc, m_pending, m_overflow, m_busy, m_granted, m_cmd_at, m_kind;
    int m_first, m_burst, m_decide_at, tm_loaded, tm_n;
    // observed events
    int ev_prea, ev_ref, ev_drop, ev_drop_pend, ev_pend1, n_prea, n_ref, max_pend, prev_req;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int max1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        cyc = 0; m_pending = 0; m_overflow = 0; m_busy = 0; m_granted = 0;
        m_cmd_at = -1; m_kind = 0; m_first = 0; m_burst = 0; m_decide_at = -1;
        tm_loaded = 0; tm_n = 0; prev_req = 0;
        exp_q.delete();
    endtask

    task automatic clear_events();
        ev_prea = -1; ev_ref = -1; ev_drop = -1; ev_drop_pend = -1; ev_pend1 = -1;
        n_prea = 0; n_ref = 0; max_pend = 0;
    endtask

    // One clock cycle: compare at the falling edge, then advance the model.
    task automatic step();
        int ucur, tick_now, cmd_now, p_n, busy_n, expv, got, run;
        logic [1:0] e;
        @(negedge core_clk);
        ucur    = (m_pending >= MAXP - 1) ? 1 : 0;
        cmd_now = (m_busy != 0 && m_granted != 0 && cyc == m_cmd_at) ? m_kind : 0;
        expv = (m_busy << 9) | ((cmd_now != 0 ? 1 : 0) << 8) | (cmd_now << 6)
             | (m_pending << 2) | (ucur << 1) | m_overflow;
        got  = int'({bus_req, cmd_valid, cmd, pending, urgent, overflow});
        chk("outputs", got, expv);
        if (cmd_now != 0) exp_q.push_back(2'(cmd_now));
        if (cmd_valid) begin
            if (exp_q.size() == 0) begin
                chk("cmd_sb_extra", int'({cmd_valid, cmd}), 0);
            end else begin
                e = exp_q.pop_front();
                chk("cmd_sb", int'(cmd), int'(e));
            end
        end
        if (cmd_valid && cmd == 2'd1) begin n_prea++; if (ev_prea < 0) ev_prea = cyc; end
        if (cmd_valid && cmd == 2'd2) begin n_ref++;  if (ev_ref < 0)  ev_ref  = cyc; end
        if (prev_req != 0 && !bus_req && ev_drop < 0) begin ev_drop = cyc; ev_drop_pend = int'(pending); end
        if (pending == 4'd1 && ev_pend1 < 0) ev_pend1 = cyc;
        if (int'(pending) > max_pend) max_pend = int'(pending);
        prev_req = bus_req ? 1 : 0;

        // interval: a tick on every trefi-th enabled cycle since the last (re)load
        run      = (tm_loaded != 0 && enable && trefi != 16'd0) ? 1 : 0;
        tick_now = (run != 0 && tm_n == int'(trefi) - 1) ? 1 : 0;
        tm_n     = (run != 0 && tick_now == 0) ? tm_n + 1 : 0;
        tm_loaded = 1;

        p_n = m_pending + ((tick_now != 0 && m_pending < MAXP) ? 1 : 0) - (cmd_now == 2 ? 1 : 0);
        if (tick_now != 0 && m_pending == MAXP) m_overflow = 1;
        busy_n = m_busy;
        if (m_busy == 0) begin
            if (enable && m_pending > 0 && (idle_hint || ucur != 0)) begin
                busy_n = 1; m_granted = 0;
            end
        end else if (m_granted == 0) begin
            if (bus_gnt) begin
                m_granted = 1; m_cmd_at = cyc + 1; m_kind = 1; m_first = 1; m_decide_at = -1;
            end
        end else begin
            if (cmd_now == 1) begin m_cmd_at = cyc + max1(int'(trp)); m_kind = 2; end
            if (m_kind == 2 && m_first != 0 && cyc == m_cmd_at - 1) m_burst = ucur;
            if (cmd_now == 2) begin m_first = 0; m_decide_at = cyc + max1(int'(trfc)) - 1; end
            if (cyc == m_decide_at) begin
                if (m_burst != 0 && p_n > 0) m_cmd_at = cyc + 1;
                else busy_n = 0;
                m_decide_at = -1;
            end
        end
        m_busy = busy_n;
        m_pending = p_n;
        cyc++;
        @(posedge core_clk);
        #1;
    endtask

    task automatic restart_interval(input int new_trefi);
        enable = 1'b0;
        trefi  = 16'(new_trefi);
        step();
        enable = 1'b1;
    endtask

    initial begin
        model_reset();
        clear_events();
        repeat (3) @(posedge core_clk);
        #1;
        chk("reset_bus_req", int'(bus_req), 0);
        chk("reset_cmd", int'({cmd_valid, cmd}), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_flags", int'({urgent, overflow}), 0);

        // basic single refresh
        enable = 1'b1; trefi = 16'd100; idle_hint = 1'b1; trp = 6'd4; trfc = 10'd10; gnt_allow = 1'b1;
        core_arst = 1'b0;
        model_reset();
        clear_events();
        repeat (130) step();
        chk("s1_first_pending", ev_pend1, 101);
        chk("s1_prea_cycle", ev_prea, 103);
        chk("s1_prea_to_ref", ev_ref - ev_prea, 4);
        chk("s1_ref_to_drop", ev_drop - ev_ref, 10);
        chk("s1_drop_pending", ev_drop_pend, 0);

        // postponed refreshes serviced as an urgent burst
        idle_hint = 1'b0;
        restart_interval(20);
        clear_events();
        repeat (300) step();
        chk("s2_max_pending", max_pend, 7);
        chk("s2_prea_count", n_prea, 1);
        chk("s2_burst_refs", (n_ref >= 7) ? 1 : 0, 1);
        chk("s2_drop_pending", ev_drop_pend, 0);

        // grant withheld: saturation and sticky overflow
        gnt_allow = 1'b0;
        restart_interval(20);
        clear_events();
        repeat (200) step();
        chk("s3_pending_sat", int'(pending), MAXP);
        chk("s3_overflow", int'(overflow), 1);
        chk("s3_req_waiting", int'({bus_req, urgent}), 3);
        gnt_allow = 1'b1;
        repeat (200) step();
        chk("s3_overflow_sticky", int'(overflow), 1);
        chk("s3_prea_count", n_prea, 1);

        // zero delays behave as one cycle
        trp = 6'd0; trfc = 10'd0; idle_hint = 1'b1;
        restart_interval(30);
        clear_events();
        repeat (80) step();
        chk("s4_prea_to_ref", ev_ref - ev_prea, 1);
        chk("s4_ref_to_drop", ev_drop - ev_ref, 1);

        // asynchronous reset in the middle of WAIT_RP
        trp = 6'd20; trfc = 10'd10;
        restart_interval(25);
        clear_events();
        for (int i = 0; i < 200 && ev_prea < 0; i++) step();
        chk("s5_prea_seen", (ev_prea >= 0) ? 1 : 0, 1);
        repeat (3) step();
        #2;
        core_arst = 1'b1;
        #1;
        chk("s5_rst_bus_req", int'(bus_req), 0);
        chk("s5_rst_cmd", int'({cmd_valid, cmd}), 0);
        chk("s5_rst_pending", int'(pending), 0);
        @(posedge core_clk);
        #1;
        core_arst = 1'b0;
        model_reset();
        clear_events();
        repeat (20) step();
        chk("s5_quiet_after_reset", n_prea + n_ref, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 300 == 150) begin
                restart_interval($urandom_range(3, 40));
                repeat ($urandom_range(0, 2)) step();
            end
            if ($urandom_range(0, 19) == 0) trp  = 6'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) trfc = 10'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)  gnt_allow = ~gnt_allow;
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            idle_hint = ($urandom_range(0, 3) != 0);
            step();
        end
        gnt_allow = 1'b1;
        idle_hint = 1'b1;
        repeat (100) step();
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
